// File: rtl/mmu_pager_pkg.sv
// Shared constants for the mmu_pager multi-window memory pager.
// Register offsets, CTRL bit positions and commit FSM state codes.
package mmu_pager_pkg;

  localparam logic [3:0] REG_PAGE0  = 4'h0;
  localparam logic [3:0] REG_CTRL   = 4'h8;
  localparam logic [3:0] REG_LOCK   = 4'h9;
  localparam logic [3:0] REG_DELAY  = 4'hA;
  localparam logic [3:0] REG_STATUS = 4'hB;

  localparam int unsigned CTRL_COMMIT  = 0;
  localparam int unsigned CTRL_DCOMMIT = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;
  localparam int unsigned CTRL_ROD     = 3;
  localparam int unsigned CTRL_RAD     = 4;
  localparam int unsigned CTRL_PENDING = 7;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

endpackage

// File: rtl/mmu_pager_commit_timer.sv
// Commit sequencer: immediate or bus-cycle-delayed copy of staged pages to active.
// commit_c is a same-clk strobe; pending is the registered COUNT state.
module mmu_pager_commit_timer
  import mmu_pager_pkg::*;
#(
  parameter int unsigned DLY_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  logic             dcommit,
  input  logic             vma,
  input  logic [DLY_W-1:0] delay,
  output logic             commit_c,
  output logic             pending
);

  logic [0:0]       state, state_nx;
  logic [DLY_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Terminal vma commits even if a CTRL write lands on the same clk; COMMIT beats DCOMMIT.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit_c = 1'b0;
    if (state == ST_COUNT && vma) begin
      if (cnt == DLY_W'(1)) begin
        commit_c = 1'b1;
        state_nx = ST_IDLE;
      end else begin
        cnt_nx = cnt - DLY_W'(1);
      end
    end
    if (commit) begin
      commit_c = 1'b1;
      state_nx = ST_IDLE;
    end else if (dcommit) begin
      if (delay == '0) begin
        commit_c = 1'b1;
        state_nx = ST_IDLE;
      end else begin
        state_nx = ST_COUNT;
        cnt_nx   = delay;
      end
    end
  end

  assign pending = (state == ST_COUNT);

endmodule

// File: rtl/mmu_pager.sv
// Multi-window CPU memory pager with staged atomic page commit and per-window write locks.
// Define MMU_PAGER_IRQ_EN to build violation logging, STATUS and irq.
module mmu_pager
  import mmu_pager_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WSEL_W = 2,
  parameter int unsigned PAGE_W = 6,
  parameter int unsigned DLY_W  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       AD,
  input  logic [7:0]                       DI,
  output logic [7:0]                       DO,
  input  logic                             rw,
  input  logic                             cs,
  input  logic [ADDR_W-1:0]                cpu_addr,
  input  logic                             cpu_rw,
  input  logic                             cpu_vma,
  output logic [PAGE_W+ADDR_W-WSEL_W-1:0]  ext_addr,
  output logic                             wr_inhibit,
  output logic                             brom_disable,
  output logic                             bram_disable,
  output logic                             irq
);

  localparam int unsigned NUM_WIN   = 2 ** WSEL_W;
  localparam int unsigned OFF_W     = ADDR_W - WSEL_W;
  localparam logic [4:0]  NUM_WIN_L = 5'(NUM_WIN);

  logic [PAGE_W-1:0]  staged [NUM_WIN];
  logic [PAGE_W-1:0]  active [NUM_WIN];
  logic [NUM_WIN-1:0] lock;
  logic [DLY_W-1:0]   delay;
  logic               rod, rad;
  logic               commit_c, pending;
  logic               irq_en, viol;
  logic [2:0]         viol_win;
  logic [7:0]         rd_data;
  logic               unused_di;

  logic              reg_wr, reg_rd, ctrl_wr, page_sel;
  logic [3:0]        page_off;
  logic [WSEL_W-1:0] page_idx, win;

  assign reg_wr   = cs & ~rw;
  assign reg_rd   = cs & rw;
  assign ctrl_wr  = reg_wr && (AD == REG_CTRL);
  assign page_off = AD - REG_PAGE0;
  assign page_sel = ({1'b0, page_off} < NUM_WIN_L);
  assign page_idx = page_off[WSEL_W-1:0];
  assign unused_di = ^DI;

  assign win        = cpu_addr[ADDR_W-1 -: WSEL_W];
  assign ext_addr   = {active[win], cpu_addr[OFF_W-1:0]};
  assign wr_inhibit = cpu_vma & ~cpu_rw & lock[win];

  mmu_pager_commit_timer #(.DLY_W(DLY_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .commit   (ctrl_wr & DI[CTRL_COMMIT]),
    .dcommit  (ctrl_wr & DI[CTRL_DCOMMIT]),
    .vma      (cpu_vma),
    .delay    (delay),
    .commit_c (commit_c),
    .pending  (pending)
  );

  // Commit copies staged as it stood before any same-clk page write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_WIN; i++) begin
        staged[i] <= PAGE_W'(i);
        active[i] <= PAGE_W'(i);
      end
    end else begin
      if (commit_c) begin
        for (int unsigned i = 0; i < NUM_WIN; i++) active[i] <= staged[i];
      end
      if (reg_wr && page_sel) staged[page_idx] <= DI[PAGE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock  <= '0;
      delay <= '0;
      rod   <= 1'b0;
      rad   <= 1'b1;
    end else if (reg_wr) begin
      case (AD)
        REG_CTRL: begin
          rod <= DI[CTRL_ROD];
          rad <= DI[CTRL_RAD];
        end
        REG_LOCK:  lock  <= DI[NUM_WIN-1:0];
        REG_DELAY: delay <= DI[DLY_W-1:0];
        default: ;
      endcase
    end
  end

`ifdef MMU_PAGER_IRQ_EN
  // A violation in the same clk as a STATUS clear keeps VIOL set.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en   <= 1'b0;
      viol     <= 1'b0;
      viol_win <= '0;
    end else begin
      if (ctrl_wr) irq_en <= DI[CTRL_IRQ_EN];
      if (wr_inhibit) begin
        viol <= 1'b1;
        if (!viol) viol_win <= 3'(win);
      end else if (reg_wr && AD == REG_STATUS && DI[0]) begin
        viol <= 1'b0;
      end
    end
  end
  assign irq = viol & irq_en;
`else
  assign irq_en   = 1'b0;
  assign viol     = 1'b0;
  assign viol_win = '0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rd_data = 8'h00;
    if (page_sel) begin
      rd_data = 8'(staged[page_idx]);
    end else begin
      case (AD)
        REG_CTRL: begin
          rd_data[CTRL_PENDING] = pending;
          rd_data[CTRL_RAD]     = rad;
          rd_data[CTRL_ROD]     = rod;
          rd_data[CTRL_IRQ_EN]  = irq_en;
        end
        REG_LOCK:   rd_data = 8'(lock);
        REG_DELAY:  rd_data = 8'(delay);
        REG_STATUS: rd_data = {4'b0000, viol_win, viol};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         DO <= 8'h00;
    else if (reg_rd) DO <= rd_data;
  end

  assign brom_disable = rod;
  assign bram_disable = rad;

endmodule

// File: tb/tb_mmu_pager.sv
// Self-checking bench for mmu_pager: directed scenarios plus random traffic vs a register-map model.
module tb_mmu_pager;

`ifdef MMU_PAGER_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  AD;
  logic [7:0]  DI, DO;
  logic        rw, cs;
  logic [15:0] cpu_addr;
  logic        cpu_rw, cpu_vma;
  logic [19:0] ext_addr;
  logic        wr_inhibit, brom_disable, bram_disable, irq;

  always #5 clk = ~clk;

  mmu_pager dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_vma(cpu_vma),
    .ext_addr(ext_addr), .wr_inhibit(wr_inhibit),
    .brom_disable(brom_disable), .bram_disable(bram_disable), .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_stg[4], m_act[4];
  int m_lock, m_delay, m_pend, m_rem, m_irqen, m_rod, m_rad, m_viol, m_vwin, m_do;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_stg[i] = i;
      m_act[i] = i;
    end
    m_lock = 0; m_delay = 0; m_pend = 0; m_rem = 0; m_irqen = 0;
    m_rod = 0; m_rad = 1; m_viol = 0; m_vwin = 0; m_do = 0;
  endfunction

  function automatic int m_read(input int ad);
    if (ad < 4) return m_stg[ad];
    case (ad)
      8:  return m_pend * 128 + m_rad * 16 + m_rod * 8 + m_irqen * 4;
      9:  return m_lock;
      10: return m_delay;
      11: return HAS_IRQ ? (m_vwin * 2 + m_viol) : 0;
      default: return 0;
    endcase
  endfunction

  // One clk of register access + CPU bus activity; exp_ext >= 0 adds a fixed translation check.
  task automatic cyc(input bit c_cs, input bit c_rw, input int c_ad, input int c_di,
                     input int c_addr, input bit c_crw, input bit c_vma, input int exp_ext);
    int win, off, inh, rdval, commit_now;
    int old_stg[4];
    cs = c_cs; rw = c_rw; AD = 4'(c_ad); DI = 8'(c_di);
    cpu_addr = 16'(c_addr); cpu_rw = c_crw; cpu_vma = c_vma;
    #1;
    win = (c_addr >> 14) & 3;
    off = c_addr & 'h3FFF;
    inh = (c_vma && !c_crw && ((m_lock >> win) & 1) == 1) ? 1 : 0;
    if (!rst) begin
      chk("ext_addr", 32'(ext_addr), 32'(m_act[win] * 16384 + off));
      chk("wr_inhibit", 32'(wr_inhibit), 32'(inh));
      if (exp_ext >= 0) chk("ext_addr_fixed", 32'(ext_addr), 32'(exp_ext));
    end
    rdval = m_read(c_ad);
    old_stg = m_stg;
    commit_now = 0;
    if (m_pend == 1 && c_vma) begin
      if (m_rem == 1) begin commit_now = 1; m_pend = 0; end
      else m_rem--;
    end
    if (c_cs && c_rw) m_do = rdval;
    if (c_cs && !c_rw) begin
      if (c_ad == 8) begin
        m_rod = (c_di >> 3) & 1;
        m_rad = (c_di >> 4) & 1;
        if (HAS_IRQ) m_irqen = (c_di >> 2) & 1;
        if ((c_di & 1) == 1) begin
          commit_now = 1; m_pend = 0;
        end else if ((c_di & 2) == 2) begin
          if (m_delay == 0) begin commit_now = 1; m_pend = 0; end
          else begin m_pend = 1; m_rem = m_delay; end
        end
      end
      if (c_ad < 4)   m_stg[c_ad] = c_di & 'h3F;
      if (c_ad == 9)  m_lock  = c_di & 'hF;
      if (c_ad == 10) m_delay = c_di & 'hF;
    end
    if (commit_now == 1) m_act = old_stg;
    if (HAS_IRQ) begin
      if (inh == 1) begin
        if (m_viol == 0) m_vwin = win;
        m_viol = 1;
      end else if (c_cs && !c_rw && c_ad == 11 && (c_di & 1) == 1) begin
        m_viol = 0;
      end
    end
    if (rst) model_reset();
    @(posedge clk);
    #1;
    chk("DO", 32'(DO), 32'(m_do));
    chk("brom_disable", 32'(brom_disable), 32'(m_rod));
    chk("bram_disable", 32'(bram_disable), 32'(m_rad));
    chk("irq", 32'(irq), 32'(m_viol & m_irqen));
  endtask

  task automatic wr(input int ad, input int di);
    cyc(1'b1, 1'b0, ad, di, 'h0000, 1'b1, 1'b0, -1);
  endtask

  task automatic rd(input int ad);
    cyc(1'b1, 1'b1, ad, 0, 'h0000, 1'b1, 1'b0, -1);
  endtask

  task automatic vma_rd(input int addr, input int exp_ext);
    cyc(1'b0, 1'b1, 0, 0, addr, 1'b1, 1'b1, exp_ext);
  endtask

  task automatic idle(input int addr, input int exp_ext);
    cyc(1'b0, 1'b1, 0, 0, addr, 1'b1, 1'b0, exp_ext);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle('h0000, -1);
    idle('h0000, -1);
    rst = 1'b0;

    // Reset state: identity map, register defaults
    idle('h4123, 'h04123);
    chk("rst_DO", 32'(DO), 32'h0);
    chk("rst_brom", 32'(brom_disable), 32'h0);
    chk("rst_bram", 32'(bram_disable), 32'h1);

    // Immediate commit of page1 = 0x2A
    cyc(1'b1, 1'b0, 1, 'h2A, 'h4123, 1'b1, 1'b0, 'h04123);
    cyc(1'b1, 1'b0, 8, 'h11, 'h4123, 1'b1, 1'b0, 'h04123);
    idle('h4123, 'hA8123);

    // Delayed commit after 3 bus cycles
    wr(10, 3);
    wr(0, 'h10);
    wr(8, 'h12);
    rd(8);
    chk("pending_set", 32'(DO[7]), 32'h1);
    vma_rd('h0123, 'h00123);
    idle('h0123, 'h00123);
    vma_rd('h0123, 'h00123);
    idle('h0123, 'h00123);
    rd(8);
    chk("pending_hold", 32'(DO[7]), 32'h1);
    vma_rd('h0123, 'h00123);
    cyc(1'b1, 1'b1, 8, 0, 'h0123, 1'b1, 1'b0, 'h40123);
    chk("pending_clr", 32'(DO[7]), 32'h0);

    // Lock violation on window 2
    wr(9, 4);
    wr(8, 'h14);
    cyc(1'b0, 1'b1, 0, 0, 'h8000, 1'b0, 1'b1, -1);
    chk("irq_after_viol", 32'(irq), 32'(HAS_IRQ));
    rd(11);
    chk("status_viol", 32'(DO), HAS_IRQ ? 32'h5 : 32'h0);
    cyc(1'b1, 1'b0, 11, 1, 'h8000, 1'b0, 1'b1, -1);
    rd(11);
    chk("status_set_wins", 32'(DO), HAS_IRQ ? 32'h5 : 32'h0);
    wr(11, 1);
    rd(11);
    wr(9, 0);

    // DCOMMIT cancelled by COMMIT after 2 vmas
    wr(3, 'h3F);
    wr(10, 5);
    wr(8, 'h12);
    vma_rd('hC000, -1);
    vma_rd('hC000, -1);
    wr(8, 'h11);
    rd(8);
    chk("pending_cancel", 32'(DO[7]), 32'h0);
    wr(3, 'h01);
    for (int i = 0; i < 6; i++) vma_rd('hC000, 'hFC000);

    // Reset in the middle of a countdown
    wr(10, 2);
    wr(2, 'h22);
    wr(8, 'h12);
    vma_rd('h8000, -1);
    rst = 1'b1;
    vma_rd('h8000, -1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) vma_rd('h8000, 'h08000);
    rd(8);
    chk("pending_after_rst", 32'(DO[7]), 32'h0);

    // Random register and bus traffic
    for (int i = 0; i < 400; i++) begin
      bit r_cs, r_rw, r_crw, r_vma;
      r_cs  = ($urandom_range(0, 2) == 0);
      r_rw  = 1'($urandom);
      r_crw = 1'($urandom);
      r_vma = 1'($urandom);
      cyc(r_cs, r_rw, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 'hFFFF)), r_crw, r_vma, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
